// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SLT  = 3'b101,
      OP_MUL  = 3'b110,
      OP_SLTU = 3'b111
   } alu_op_e;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } alu_state_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle of alu_pipe; slave is the ALU side, master the producer/consumer.
interface alu_pipe_if #(
   parameter int unsigned WIDTH = 32
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic [2:0]       ALUControl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALUResult;
   logic             Zero;
   logic             Neg;
   logic             Carry;
   logic             Ovf;

   modport master (
      output in_valid, SrcA, SrcB, ALUControl, out_ready,
      input  in_ready, out_valid, ALUResult, Zero, Neg, Carry, Ovf
   );

   modport slave (
      input  in_valid, SrcA, SrcB, ALUControl, out_ready,
      output in_ready, out_valid, ALUResult, Zero, Neg, Carry, Ovf
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, low WIDTH bits of the product.
module alu_mul_iter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      a_d    = a_q;
      b_d    = b_q;
      acc_d  = acc_q;
      if (start_i && !busy_q) begin
         busy_d = 1'b1;
         cnt_d  = CNT_W'(WIDTH);
         a_d    = a_i;
         b_d    = b_i;
         acc_d  = '0;
      end else if (busy_q) begin
         // The cycle after the last step is the done cycle; the top samples the product then.
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = busy_q && (cnt_q == '0);
   assign product_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and Z/N/C/V flags.
// Define ALU_MUL_EN to enable the iterative multiplier for opcode 110.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input logic       clk,
   input logic       rst_n,
   alu_pipe_if.slave bus
);

   localparam int unsigned Msb = WIDTH - 1;

   if (WIDTH < 4 || CNT_W != $clog2(WIDTH + 1)) begin : g_bad_param
      $error("alu_pipe: WIDTH must be >= 4 and CNT_W must not be overridden");
   end

   logic             in_fire, out_fire;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   alu_flags_t       flags_q, flags_d;
   logic [WIDTH-1:0] alu_res;
   alu_flags_t       alu_flags;
   logic [WIDTH:0]   sum, diff;
   alu_op_e          op;

   assign op       = alu_op_e'(bus.ALUControl);
   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = out_valid_q && bus.out_ready;

   always_comb begin
      sum       = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
      diff      = {1'b0, bus.SrcA} + {1'b0, ~bus.SrcB} + (WIDTH + 1)'(1);
      alu_res   = '0;
      alu_flags = '0;
      unique case (op)
         OP_ADD: begin
            alu_res     = sum[WIDTH-1:0];
            alu_flags.c = sum[WIDTH];
            alu_flags.v = (bus.SrcA[Msb] == bus.SrcB[Msb]) && (sum[Msb] != bus.SrcA[Msb]);
         end
         OP_SUB: begin
            // Carry is the inverted borrow, i.e. A >= B unsigned.
            alu_res     = diff[WIDTH-1:0];
            alu_flags.c = diff[WIDTH];
            alu_flags.v = (bus.SrcA[Msb] != bus.SrcB[Msb]) && (diff[Msb] != bus.SrcA[Msb]);
         end
         OP_AND:  alu_res = bus.SrcA & bus.SrcB;
         OP_OR:   alu_res = bus.SrcA | bus.SrcB;
         OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.SrcA < bus.SrcB};
         OP_MUL:  alu_res = '0;
      endcase
      alu_flags.z = (alu_res == '0);
      alu_flags.n = alu_res[Msb];
   end

`ifdef ALU_MUL_EN
   localparam logic [0:0] StIdle = S_IDLE;
   localparam logic [0:0] StMul  = S_MUL;

   logic [0:0]       state_q, state_d;
   logic             mul_start, mul_busy, mul_done;
   logic [WIDTH-1:0] mul_product;

   alu_mul_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (mul_start),
      .a_i       (bus.SrcA),
      .b_i       (bus.SrcB),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_product)
   );

   assign bus.in_ready = (state_q == StIdle) && !mul_busy && (!out_valid_q || bus.out_ready);

   always_comb begin
      state_d     = state_q;
      mul_start   = 1'b0;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      if (out_fire) out_valid_d = 1'b0;
      if (state_q == StMul) begin
         if (mul_done) begin
            state_d     = StIdle;
            result_d    = mul_product;
            flags_d     = '0;
            flags_d.z   = (mul_product == '0);
            flags_d.n   = mul_product[Msb];
            out_valid_d = 1'b1;
         end
      end else if (in_fire) begin
         if (op == OP_MUL) begin
            state_d   = StMul;
            mul_start = 1'b1;
         end else begin
            result_d    = alu_res;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end
`else
   assign bus.in_ready = !out_valid_q || bus.out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      if (out_fire) out_valid_d = 1'b0;
      if (in_fire) begin
         result_d    = alu_res;
         flags_d     = alu_flags;
         out_valid_d = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.ALUResult = result_q;
   assign bus.Zero      = flags_q.z;
   assign bus.Neg       = flags_q.n;
   assign bus.Carry     = flags_q.c;
   assign bus.Ovf       = flags_q.v;

endmodule
